keypad_code_lock: RTL and testbench

Code-lock controller that consumes decoded keypad events (one-cycle `key_valid` pulse with 4-bit hex `key`) from the keypad scanner. It assembles digit entries, compares them against a stored code, drives lock/unlock status and enforces a lockout after repeated failures. The stored code can be reprogrammed while unlocked. Outputs feed the seven-segment display and the actuator logic.

---
 rtl/keypad_code_lock_if.sv | 54 +++++
 rtl/keypad_code_lock.sv | 266 ++++++++++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_code_lock_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_code_lock_if
// Description : Key-event input and status/pulse outputs of the keypad code
//               lock, bundled for connection between the keypad scanner side
//               (master) and the lock controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_code_lock_if #(
    parameter int CODE_LEN = 4
);
    // Key event from the keypad scanner
    logic [3:0]            key;
    logic                  key_valid;

    // Status towards display and actuator logic
    logic [4*CODE_LEN-1:0] entry_digits;
    logic [2:0]            entry_count;
    logic                  unlocked;
    logic                  locked_out;
    logic                  set_mode;
    logic [1:0]            fail_count;
    logic                  ok_pulse;
    logic                  err_pulse;

    // Scanner / environment side: produces key events, observes status
    modport master (
        output key,
        output key_valid,
        input  entry_digits,
        input  entry_count,
        input  unlocked,
        input  locked_out,
        input  set_mode,
        input  fail_count,
        input  ok_pulse,
        input  err_pulse
    );

    // Lock controller side: consumes key events, drives status
    modport slave (
        input  key,
        input  key_valid,
        output entry_digits,
        output entry_count,
        output unlocked,
        output locked_out,
        output set_mode,
        output fail_count,
        output ok_pulse,
        output err_pulse
    );
endinterface
`default_nettype wire

// File: rtl/keypad_code_lock.sv
`default_nettype none
// ============================================================================
// Module      : keypad_code_lock
// Description : Code-lock controller. Collects hex key events into a digit
//               buffer, compares against a reprogrammable stored code, and
//               manages unlock, code-set, inactivity timeout and lockout after
//               repeated failures. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_code_lock #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCKOUT_CYCLES = 300_000_000,
    parameter int                    UNLOCK_CYCLES  = 500_000_000
) (
    input  logic              clk,
    input  logic              reset,
    keypad_code_lock_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_DW       = 4 * CODE_LEN;
    localparam int         c_TMR_MAX  = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
                                        LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int         c_TW       = $clog2(c_TMR_MAX + 1);
    localparam logic [2:0] c_LEN      = 3'(CODE_LEN);
    localparam logic [1:0] c_MAX_FAIL = 2'(MAX_FAIL);
    localparam logic [c_TW-1:0] c_T_UNLOCK  = c_TW'(UNLOCK_CYCLES);
    localparam logic [c_TW-1:0] c_T_LOCKOUT = c_TW'(LOCKOUT_CYCLES);

    localparam logic [3:0] c_KEY_CLEAR = 4'hA;
    localparam logic [3:0] c_KEY_BACK  = 4'hB;
    localparam logic [3:0] c_KEY_ENTER = 4'hE;
    localparam logic [3:0] c_KEY_SET   = 4'hF;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_SET_CODE = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_DW-1:0]   r_code;
    logic [c_DW-1:0]   w_code_nxt;
    logic [c_DW-1:0]   r_digits;
    logic [c_DW-1:0]   w_digits_nxt;
    logic [2:0]        r_count;
    logic [2:0]        w_count_nxt;
    logic [1:0]        r_fail;
    logic [1:0]        w_fail_nxt;
    logic [c_TW-1:0]   r_timer;
    logic [c_TW-1:0]   w_timer_nxt;
    logic              r_ok;
    logic              w_ok_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_unlocked;
    logic              r_locked_out;
    logic              r_set_mode;

    // Key classification, qualified by the strobe
    logic w_is_digit;
    logic w_is_clear;
    logic w_is_back;
    logic w_is_enter;
    logic w_is_set;

    // Result of applying the current key to the digit buffer
    logic [c_DW-1:0] w_edit_digits;
    logic [2:0]      w_edit_count;
    logic            w_edit_accept;
    logic            w_edit_reject;

    logic            w_match;
    logic            w_expire;
    logic [1:0]      w_fail_inc;

    assign w_is_digit = bus.key_valid && (bus.key <= 4'd9);
    assign w_is_clear = bus.key_valid && (bus.key == c_KEY_CLEAR);
    assign w_is_back  = bus.key_valid && (bus.key == c_KEY_BACK);
    assign w_is_enter = bus.key_valid && (bus.key == c_KEY_ENTER);
    assign w_is_set   = bus.key_valid && (bus.key == c_KEY_SET);

    // A full buffer of the right length that equals the stored code
    assign w_match    = (r_count == c_LEN) && (r_digits == r_code);
    // Timed states leave in the cycle the counter steps from 1 to 0
    assign w_expire   = (r_timer == c_TW'(1));
    assign w_fail_inc = r_fail + 2'd1;

    // Digit-buffer edit for the current key (digit push, clear, backspace)
    always_comb begin
        w_edit_digits = r_digits;
        w_edit_count  = r_count;
        w_edit_accept = 1'b0;
        w_edit_reject = 1'b0;
        if (w_is_digit) begin
            if (r_count < c_LEN) begin
                w_edit_digits = (r_digits << 4) | c_DW'(bus.key);
                w_edit_count  = r_count + 3'd1;
                w_edit_accept = 1'b1;
            end else begin
                w_edit_reject = 1'b1;
            end
        end else if (w_is_clear) begin
            w_edit_digits = '0;
            w_edit_count  = '0;
            w_edit_accept = 1'b1;
        end else if (w_is_back) begin
            w_edit_accept = 1'b1;
            if (r_count != 3'd0) begin
                w_edit_digits = r_digits >> 4;
                w_edit_count  = r_count - 3'd1;
            end
        end
    end

    // Next-state and next-output decode for the lock controller
    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_digits_nxt = r_digits;
        w_count_nxt  = r_count;
        w_fail_nxt   = r_fail;
        w_timer_nxt  = (r_timer != '0) ? (r_timer - c_TW'(1)) : '0;
        w_ok_nxt     = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            ST_ENTRY: begin
                if (w_is_enter) begin
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                    if (w_match) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_ok_nxt    = 1'b1;
                        w_fail_nxt  = '0;
                        w_timer_nxt = c_T_UNLOCK;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (w_fail_inc == c_MAX_FAIL) begin
                            w_state_nxt = ST_LOCKOUT;
                            w_timer_nxt = c_T_LOCKOUT;
                            w_fail_nxt  = '0;
                        end else begin
                            w_fail_nxt = w_fail_inc;
                        end
                    end
                end else begin
                    // Set key and C/D fall through here untouched
                    w_digits_nxt = w_edit_digits;
                    w_count_nxt  = w_edit_count;
                    w_err_nxt    = w_edit_reject;
                end
            end

            ST_UNLOCKED: begin
                if (w_expire) begin
                    // Expiry wins over any key arriving this cycle
                    w_state_nxt  = ST_ENTRY;
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                end else if (w_is_enter) begin
                    w_state_nxt  = ST_ENTRY;
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                    w_timer_nxt  = '0;
                end else if (w_is_set) begin
                    w_state_nxt  = ST_SET_CODE;
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                    w_timer_nxt  = c_T_UNLOCK;
                end else if (bus.key_valid) begin
                    w_timer_nxt = c_T_UNLOCK;
                end
            end

            ST_SET_CODE: begin
                if (w_expire) begin
                    // Abandon the new code; nothing is committed
                    w_state_nxt  = ST_ENTRY;
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                end else if (w_is_enter) begin
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                    if (r_count == c_LEN) begin
                        w_code_nxt  = r_digits;
                        w_ok_nxt    = 1'b1;
                        w_state_nxt = ST_ENTRY;
                        w_timer_nxt = '0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_timer_nxt = c_T_UNLOCK;
                    end
                end else begin
                    w_digits_nxt = w_edit_digits;
                    w_count_nxt  = w_edit_count;
                    w_err_nxt    = w_edit_reject;
                    if (w_edit_accept) begin
                        w_timer_nxt = c_T_UNLOCK;
                    end
                end
            end

            ST_LOCKOUT: begin
                // Keys are discarded; only the timer can release the lock
                if (w_expire) begin
                    w_state_nxt = ST_ENTRY;
                end
            end

            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    // State, buffer, code, timer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ENTRY;
            r_code       <= DEFAULT_CODE;
            r_digits     <= '0;
            r_count      <= '0;
            r_fail       <= '0;
            r_timer      <= '0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_set_mode   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_code       <= w_code_nxt;
            r_digits     <= w_digits_nxt;
            r_count      <= w_count_nxt;
            r_fail       <= w_fail_nxt;
            r_timer      <= w_timer_nxt;
            r_ok         <= w_ok_nxt;
            r_err        <= w_err_nxt;
            r_unlocked   <= (w_state_nxt == ST_UNLOCKED) ||
                            (w_state_nxt == ST_SET_CODE);
            r_locked_out <= (w_state_nxt == ST_LOCKOUT);
            r_set_mode   <= (w_state_nxt == ST_SET_CODE);
        end
    end

    assign bus.entry_digits = r_digits;
    assign bus.entry_count  = r_count;
    assign bus.unlocked     = r_unlocked;
    assign bus.locked_out   = r_locked_out;
    assign bus.set_mode     = r_set_mode;
    assign bus.fail_count   = r_fail;
    assign bus.ok_pulse     = r_ok;
    assign bus.err_pulse    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_code_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_code_lock
// Description : Directed bench for keypad_code_lock with a behavioural model
//               (digit queue, mode, deadline cycle) checked every cycle, plus
//               literal expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_code_lock;

    localparam int CODE_LEN = 4;
    localparam int LOCK_N   = 20;
    localparam int UNL_N    = 30;

    localparam int M_ENTRY    = 0;
    localparam int M_UNLOCKED = 1;
    localparam int M_SET      = 2;
    localparam int M_LOCKOUT  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_code_lock_if #(.CODE_LEN(CODE_LEN)) bus ();

    keypad_code_lock #(
        .CODE_LEN      (CODE_LEN),
        .DEFAULT_CODE  (16'h1234),
        .MAX_FAIL      (3),
        .LOCKOUT_CYCLES(LOCK_N),
        .UNLOCK_CYCLES (UNL_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_mode;
    int m_buf[$];
    int m_code[$];
    int m_fails;
    int m_deadline;
    int m_cyc = 0;
    bit m_ok;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int buf_value();
        int v = 0;
        foreach (m_buf[i]) v = v * 16 + m_buf[i];
        return v;
    endfunction

    function automatic bit buf_is_code();
        if (m_buf.size() != m_code.size()) return 1'b0;
        foreach (m_buf[i]) if (m_buf[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edit(input int k, output bit acc, output bit rej);
        acc = 1'b0;
        rej = 1'b0;
        if (k <= 9) begin
            if (m_buf.size() < CODE_LEN) begin
                m_buf.push_back(k);
                acc = 1'b1;
            end else begin
                rej = 1'b1;
            end
        end else if (k == 10) begin
            m_buf.delete();
            acc = 1'b1;
        end else if (k == 11) begin
            acc = 1'b1;
            if (m_buf.size() > 0) void'(m_buf.pop_back());
        end
    endtask

    task automatic model_tick(input bit rst, input bit kv, input int k);
        bit acc, rej;
        m_cyc++;
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_mode  = M_ENTRY;
            m_buf.delete();
            m_code  = {1, 2, 3, 4};
            m_fails = 0;
            return;
        end
        if (m_mode != M_ENTRY && m_cyc == m_deadline) begin
            m_mode = M_ENTRY;
            m_buf.delete();
            return;
        end
        if (!kv) return;
        case (m_mode)
            M_ENTRY: begin
                if (k == 14) begin
                    if (buf_is_code()) begin
                        m_mode     = M_UNLOCKED;
                        m_ok       = 1'b1;
                        m_fails    = 0;
                        m_deadline = m_cyc + UNL_N;
                    end else begin
                        m_err = 1'b1;
                        m_fails++;
                        if (m_fails == 3) begin
                            m_mode     = M_LOCKOUT;
                            m_deadline = m_cyc + LOCK_N;
                            m_fails    = 0;
                        end
                    end
                    m_buf.delete();
                end else begin
                    model_edit(k, acc, rej);
                    m_err = rej;
                end
            end
            M_UNLOCKED: begin
                if (k == 14) begin
                    m_mode = M_ENTRY;
                end else if (k == 15) begin
                    m_mode = M_SET;
                    m_buf.delete();
                    m_deadline = m_cyc + UNL_N;
                end else begin
                    m_deadline = m_cyc + UNL_N;
                end
            end
            M_SET: begin
                if (k == 14) begin
                    if (m_buf.size() == CODE_LEN) begin
                        m_code = m_buf;
                        m_ok   = 1'b1;
                        m_mode = M_ENTRY;
                    end else begin
                        m_err      = 1'b1;
                        m_deadline = m_cyc + UNL_N;
                    end
                    m_buf.delete();
                end else begin
                    model_edit(k, acc, rej);
                    m_err = rej;
                    if (acc) m_deadline = m_cyc + UNL_N;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("entry_digits", 32'(bus.entry_digits), buf_value());
        check("entry_count",  32'(bus.entry_count),  m_buf.size());
        check("unlocked",     32'(bus.unlocked),     (m_mode == M_UNLOCKED) || (m_mode == M_SET));
        check("locked_out",   32'(bus.locked_out),   m_mode == M_LOCKOUT);
        check("set_mode",     32'(bus.set_mode),     m_mode == M_SET);
        check("fail_count",   32'(bus.fail_count),   m_fails);
        check("ok_pulse",     32'(bus.ok_pulse),     m_ok);
        check("err_pulse",    32'(bus.err_pulse),    m_err);
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic cyc(input bit kv, input int k);
        bus.key_valid = kv;
        bus.key       = kv ? 4'(k) : 4'h0;
        @(posedge clk);
        model_tick(reset, kv, k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic seq(input int ks[$]);
        foreach (ks[i]) cyc(1'b1, ks[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key       = 4'h0;
        @(negedge clk);
        cyc(0, 0);
        cyc(0, 0);
        reset = 1'b0;
        check("rst_count", 32'(bus.entry_count), 0);
        check("rst_unlocked", 32'(bus.unlocked), 0);

        // Correct default code
        seq({1, 2, 3, 4, 14});
        check("t1_ok", 32'(bus.ok_pulse), 1);
        check("t1_unlocked", 32'(bus.unlocked), 1);
        check("t1_fail", 32'(bus.fail_count), 0);
        check("t1_count", 32'(bus.entry_count), 0);
        cyc(1, 14);
        check("relock", 32'(bus.unlocked), 0);

        // Backspace and overflow
        seq({1, 2, 5, 11, 3, 4, 14});
        check("t2_unlocked", 32'(bus.unlocked), 1);
        cyc(1, 14);
        seq({1, 2, 3, 4, 5});
        check("t2_err", 32'(bus.err_pulse), 1);
        check("t2_digits", 32'(bus.entry_digits), 32'h1234);
        seq({10, 11, 11, 12, 13, 15});
        check("t2_cleared", 32'(bus.entry_count), 0);

        // Three failures lead to lockout
        seq({9, 9, 9, 9, 14});
        check("t3_fail1", 32'(bus.fail_count), 1);
        seq({9, 9, 9, 9, 14});
        check("t3_fail2", 32'(bus.fail_count), 2);
        seq({9, 9, 9, 9, 14});
        check("t3_locked", 32'(bus.locked_out), 1);
        check("t3_fail0", 32'(bus.fail_count), 0);
        n = 0;
        while (bus.locked_out === 1'b1 && n < 100) begin
            n++;
            cyc(n < 8, (n % 2) ? 14 : 1);
        end
        check("lockout_len", n, LOCK_N);

        // Reprogram the code
        seq({1, 2, 3, 4, 14, 15});
        check("t4_set", 32'(bus.set_mode), 1);
        seq({5, 6, 7, 8, 14});
        check("t4_ok", 32'(bus.ok_pulse), 1);
        check("t4_locked", 32'(bus.unlocked), 0);
        seq({1, 2, 3, 4, 14});
        check("t4_old_rej", 32'(bus.err_pulse), 1);
        seq({5, 6, 7, 8, 14});
        check("t4_new_ok", 32'(bus.unlocked), 1);

        // Inactivity timeout
        n = 0;
        while (bus.unlocked === 1'b1 && n < 100) begin
            n++;
            cyc(0, 0);
        end
        check("timeout_len", n, UNL_N);
        seq({5, 6, 7, 8, 14});
        n = 0;
        while (bus.unlocked === 1'b1 && n < 200) begin
            n++;
            cyc(n == 20, 13);
        end
        check("timeout_reload", n, 50);

        // Short commit in set mode, then timeout out of set mode
        seq({5, 6, 7, 8, 14, 15, 1, 2, 14});
        check("t6_short_err", 32'(bus.err_pulse), 1);
        check("t6_still_set", 32'(bus.set_mode), 1);
        seq({3});
        n = 0;
        while (bus.set_mode === 1'b1 && n < 100) begin
            n++;
            cyc(0, 0);
        end
        check("set_timeout", n, UNL_N);

        // Key in the expiry cycle is discarded
        seq({5, 6, 7, 8, 14});
        repeat (UNL_N - 1) cyc(0, 0);
        cyc(1, 15);
        check("expiry_wins", 32'(bus.set_mode), 0);
        check("expiry_unl", 32'(bus.unlocked), 0);

        // Reset mid-entry restores the default code
        seq({1, 2});
        check("t7_partial", 32'(bus.entry_count), 2);
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        check("t7_rst_count", 32'(bus.entry_count), 0);
        check("t7_rst_digits", 32'(bus.entry_digits), 0);
        seq({1, 2, 3, 4, 14});
        check("t7_default", 32'(bus.unlocked), 1);

        // Reset mid-lockout
        cyc(1, 14);
        seq({0, 14, 0, 14, 0, 14});
        check("t8_lock", 32'(bus.locked_out), 1);
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        check("t8_rst_lock", 32'(bus.locked_out), 0);
        cyc(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
